// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FPMUL single-precision multiply engine.
// Holds the FSM state enum, register map, IEEE constants and special-case classifier.
package fpmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_MUL,
      ST_NORM,
      ST_DONE
   } state_e;

   localparam logic [1:0] REG_OPA  = 2'd0;
   localparam logic [1:0] REG_OPB  = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;
   localparam logic [1:0] REG_RES  = 2'd3;

   localparam int          EXP_BIAS = 127;
   localparam logic [31:0] QNAN     = 32'h7FC00000;

   typedef enum logic [1:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_INF,
      CLS_NAN
   } cls_e;

   // Exponent field 0 counts as zero, so denormal inputs are flushed here.
   function automatic cls_e classify(input logic [31:0] a, input logic [31:0] b);
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      cls_e cls;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         cls = CLS_NAN;
      end else if (a_inf || b_inf) begin
         cls = CLS_INF;
      end else if (a_zero || b_zero) begin
         cls = CLS_ZERO;
      end else begin
         cls = CLS_NORMAL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/fpmul_mant_seq.sv
// Bit-serial shift-add significand multiplier: start loads and examines bit 0,
// then one multiplier bit per cycle; valid pulses 24 cycles after start.
module fpmul_mant_seq
   import fpmul_pkg::*;
#(
   parameter int MANT_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [MANT_W-1:0]     a,
   input  logic [MANT_W-1:0]     b,
   output logic [2*MANT_W-1:0]   prod,
   output logic                  valid
);

   logic [2*MANT_W-1:0] acc_q;
   logic [2*MANT_W-1:0] mcand_q;
   logic [MANT_W-1:0]   mplier_q;
   logic [4:0]          cnt_q;
   logic                run_q;
   logic                valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (start) begin
            acc_q    <= b[0] ? {{MANT_W{1'b0}}, a} : '0;
            mcand_q  <= {{(MANT_W-1){1'b0}}, a, 1'b0};
            mplier_q <= b >> 1;
            cnt_q    <= 5'd1;
            run_q    <= 1'b1;
         end else if (run_q) begin
            if (mplier_q[0]) begin
               acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'(MANT_W - 1)) begin
               run_q   <= 1'b0;
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign prod  = acc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fpmul_core.sv
// Memory-mapped FP32 multiplier: GO to done in 27 edges; writes/GO while busy are dropped.
// Rounding is truncation unless FPMUL_RNE_EN is defined (round-to-nearest-even).
module fpmul_core
   import fpmul_pkg::*;
#(
   parameter int MANT_W    = 24,
   parameter bit LAT_CHECK = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we0,
   input  logic        we1,
   input  logic        we2,
   input  logic [31:0] wd,
   input  logic [1:0]  rd_sel,
   output logic [31:0] rd,
   output logic        busy,
   output logic        done
);

   state_e state_q, state_d;

   logic [31:0]          opa_q, opb_q;
   logic [31:0]          snap_a_q, snap_b_q;
   logic [31:0]          resn_q, res_q;
   logic                 busy_q, done_q;
   logic                 sign_q;
   logic signed [9:0]    exp_q;
   cls_e                 cls_q;

   logic                 go;
   logic                 op_wr_en;
   logic                 seq_start;
   logic [MANT_W-1:0]    mant_a, mant_b;
   logic [2*MANT_W-1:0]  prod;
   logic                 prod_vld;
   logic [31:0]          norm_res;

   assign go       = we2 && wd[0];
   assign op_wr_en = !busy_q || (state_q == ST_DONE);

   // Snapshots taken on the GO edge, so a same-cycle operand write is not seen.
   assign mant_a = (snap_a_q[30:23] == 8'h00) ? '0 : {1'b1, snap_a_q[22:0]};
   assign mant_b = (snap_b_q[30:23] == 8'h00) ? '0 : {1'b1, snap_b_q[22:0]};

   fpmul_mant_seq #(.MANT_W(MANT_W)) u_mant_seq (
      .clk   (clk),
      .rst   (rst),
      .start (seq_start),
      .a     (mant_a),
      .b     (mant_b),
      .prod  (prod),
      .valid (prod_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      seq_start = 1'b0;
      case (state_q)
         ST_IDLE:   if (go) state_d = ST_UNPACK;
         ST_UNPACK: begin
            seq_start = 1'b1;
            state_d   = ST_MUL;
         end
         ST_MUL:    if (prod_vld) state_d = ST_NORM;
         ST_NORM:   state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      logic                 hi;
      logic [MANT_W-2:0]    mant;
      logic signed [9:0]    exp_n;
`ifdef FPMUL_RNE_EN
      logic                 guard, rnd, sticky, carry;
`endif
      hi    = prod[2*MANT_W-1];
      mant  = hi ? prod[2*MANT_W-2 -: MANT_W-1] : prod[2*MANT_W-3 -: MANT_W-1];
      exp_n = exp_q + (hi ? 10'sd1 : 10'sd0);
`ifdef FPMUL_RNE_EN
      guard  = hi ? prod[MANT_W-1] : prod[MANT_W-2];
      rnd    = hi ? prod[MANT_W-2] : prod[MANT_W-3];
      sticky = hi ? (|prod[MANT_W-3:0]) : (|prod[MANT_W-4:0]);
      carry  = 1'b0;
      if (guard && (rnd || sticky || mant[0])) begin
         {carry, mant} = {1'b0, mant} + {{(MANT_W-1){1'b0}}, 1'b1};
      end
      // Fraction wrapped to zero: value is now 2.0, i.e. 1.0 at the next exponent.
      if (carry) begin
         exp_n = exp_n + 10'sd1;
      end
`endif
      case (cls_q)
         CLS_NAN:  norm_res = QNAN;
         CLS_INF:  norm_res = {sign_q, 8'hFF, 23'd0};
         CLS_ZERO: norm_res = {sign_q, 31'd0};
         default: begin
            if (exp_n >= 10'sd255) begin
               norm_res = {sign_q, 8'hFF, 23'd0};
            end else if (exp_n <= 10'sd0) begin
               norm_res = {sign_q, 31'd0};
            end else begin
               norm_res = {sign_q, exp_n[7:0], mant};
            end
         end
      endcase
   end

`ifndef FPMUL_RNE_EN
   logic unused_prod_lo;
   assign unused_prod_lo = ^prod[MANT_W-2:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_q    <= '0;
         opb_q    <= '0;
         snap_a_q <= '0;
         snap_b_q <= '0;
         resn_q   <= '0;
         res_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         cls_q    <= CLS_NORMAL;
      end else begin
         if (we0 && op_wr_en) opa_q <= wd;
         if (we1 && op_wr_en) opb_q <= wd;
         if (state_q == ST_IDLE && go) begin
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            snap_a_q <= opa_q;
            snap_b_q <= opb_q;
         end
         if (state_q == ST_UNPACK) begin
            sign_q <= snap_a_q[31] ^ snap_b_q[31];
            exp_q  <= ({2'b00, snap_a_q[30:23]} + {2'b00, snap_b_q[30:23]}) - 10'(EXP_BIAS);
            cls_q  <= classify(snap_a_q, snap_b_q);
         end
         if (state_q == ST_NORM) resn_q <= norm_res;
         if (state_q == ST_DONE) begin
            res_q  <= resn_q;
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd = '0;
      case (rd_sel)
         REG_OPA:  rd = opa_q;
         REG_OPB:  rd = opb_q;
         REG_STAT: rd = {30'd0, done_q, busy_q};
         REG_RES:  rd = res_q;
         default:  rd = '0;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;

   generate
      if (LAT_CHECK) begin : g_lat_chk
         logic [5:0] lat_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lat_q <= '0;
            end else if (state_q == ST_IDLE) begin
               lat_q <= '0;
            end else begin
               lat_q <= lat_q + 6'd1;
            end
         end
         a_done_lat : assert property (@(posedge clk) disable iff (rst)
            (state_q == ST_DONE) |-> (lat_q == 6'd26));
      end
   endgenerate

endmodule

// File: tb/tb_fpmul_core.sv
// Randomised bench for fpmul_core against an integer-arithmetic FP32 multiply model.
module tb_fpmul_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        we0, we1, we2;
   logic [31:0] wd;
   logic [1:0]  rd_sel;
   logic [31:0] rd;
   logic        busy, done;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   fpmul_core dut (
      .clk    (clk),
      .rst    (rst),
      .we0    (we0),
      .we1    (we1),
      .we2    (we2),
      .wd     (wd),
      .rd_sel (rd_sel),
      .rd     (rd),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, normalise, then truncate or round half-to-even.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      int ea, eb, e, sh;
      logic [63:0] p, q;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      if (p >= 64'h0000_8000_0000_0000) begin
         sh = 24;
         e  = ea + eb - 126;
      end else begin
         sh = 23;
         e  = ea + eb - 127;
      end
      q = p >> sh;
`ifdef FPMUL_RNE_EN
      begin : rne
         logic [63:0] rem, half;
         rem  = p - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q[24]) begin
            q = q >> 1;
            e = e + 1;
         end
      end
`endif
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      int k;
      v = $urandom;
      k = $urandom_range(0, 11);
      if (k < 7)       v[30:23] = 8'($urandom_range(64, 190));
      else if (k == 7) v[30:23] = 8'h00;
      else if (k == 8) v = {v[31], 8'hFF, 23'd0};
      else if (k == 9) v[30:23] = 8'hFF;
      else if (k == 10) begin
         v[30:23] = 8'($urandom_range(100, 150));
         v[22:0]  = 23'h7FFFFF;
      end
      return v;
   endfunction

   task automatic wr(input logic [1:0] which, input logic [31:0] d);
      @(negedge clk);
      we0 = (which == 2'd0);
      we1 = (which == 2'd1);
      wd  = d;
      @(negedge clk);
      we0 = 1'b0;
      we1 = 1'b0;
      wd  = '0;
   endtask

   task automatic rdreg(input logic [1:0] s, output logic [31:0] v);
      rd_sel = s;
      #1;
      v = rd;
   endtask

   task automatic go_op(output int g);
      @(negedge clk);
      we2 = 1'b1;
      wd  = 32'd1;
      @(posedge clk);
      #1;
      we2 = 1'b0;
      wd  = '0;
      g   = cyc;
   endtask

   task automatic wait_done(input int g, output int lat, output int bad);
      bad = 0;
      while (done !== 1'b1 && (cyc - g) < 60) begin
         if (busy !== 1'b1) bad++;
         @(posedge clk);
         #1;
      end
      lat = cyc - g;
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      int g, lat, bad;
      logic [31:0] v;
      wr(2'd0, a);
      wr(2'd1, b);
      go_op(g);
      wait_done(g, lat, bad);
      chk({tag, "_lat"}, lat, 27);
      chk({tag, "_busy_span"}, bad, 0);
      rdreg(2'd2, v);
      chk({tag, "_stat"}, v, 32'd2);
      rdreg(2'd3, v);
      chk(tag, v, exp);
   endtask

   initial begin
      int g, lat, bad;
      logic [31:0] v, a, b;
      rst = 1'b1; we0 = 0; we1 = 0; we2 = 0; wd = '0; rd_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rdreg(2'(i), v);
         chk("rst_reg", v, 32'd0);
      end
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      run_mul("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000);
      run_mul("neg_two_x_three", 32'hC0000000, 32'h40400000, 32'hC0C00000);
      run_mul("1p5_sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
`ifdef FPMUL_RNE_EN
      run_mul("round_case", 32'h3FC00001, 32'h3FC00001, 32'h40100002);
`else
      run_mul("round_case", 32'h3FC00001, 32'h3FC00001, 32'h40100001);
`endif
      run_mul("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
      run_mul("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
      run_mul("zero_x_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000);
      run_mul("neg_inf_x_two", 32'hFF800000, 32'h40000000, 32'hFF800000);
      run_mul("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000);

      // Writes and a second GO issued mid-operation must be dropped.
      wr(2'd0, 32'h40400000);
      wr(2'd1, 32'h40000000);
      go_op(g);
      repeat (5) @(posedge clk);
      wr(2'd0, 32'h40000000);
      rdreg(2'd0, v);
      chk("opa_hold_busy", v, 32'h40400000);
      @(negedge clk);
      we2 = 1'b1;
      wd  = 32'd1;
      @(negedge clk);
      we2 = 1'b0;
      wd  = '0;
      wait_done(g, lat, bad);
      chk("busy_go_lat", lat, 27);
      rdreg(2'd3, v);
      chk("busy_go_res", v, 32'h40C00000);
      bad = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || done !== 1'b1) bad++;
      end
      chk("single_completion", bad, 0);
      wr(2'd0, 32'h3FC00000);
      wr(2'd1, 32'h3FC00000);
      go_op(g);
      chk("done_clr_on_go", done, 0);
      wait_done(g, lat, bad);
      chk("rego_lat", lat, 27);
      rdreg(2'd3, v);
      chk("rego_res", v, 32'h40100000);

      // Asynchronous reset in the middle of the multiply loop.
      go_op(g);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      rdreg(2'd3, v);
      chk("midrst_res", v, 32'd0);
      rdreg(2'd0, v);
      chk("midrst_opa", v, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_mul("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000);

      for (int i = 0; i < 120; i++) begin
         a = rnd_fp();
         b = rnd_fp();
         run_mul("rand", a, b, ref_mul(a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
